traffic_request_latch: RTL and testbench

Front end for the two-street traffic controller: it turns raw vehicle-sensor inputs for the main and first streets into the clean, sticky waiting_main and waiting_first requests the controller consumes. It also watches the controller's green outputs so it can retire a request once that street has been served. It flags starvation when a request waits too long, and flags an illegal both-green condition. It sits between the sensor pads and the controller's waiting inputs; the controller's green outputs feed back into it.

---
 rtl/traffic_req_pkg.sv | 27 ++
 rtl/traffic_req_chan.sv | 141 ++++++++++++++
 rtl/traffic_request_latch.sv | 79 +++++++
 tb/tb_traffic_request_latch.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/traffic_req_pkg.sv
// traffic_req_pkg
// Shared types and constants for the traffic request front end.
//   chan_state_e : per-street request channel state
//   *CntW        : counter widths (debounce, service, wait)
//   wait_inc     : saturating increment for the wait counter
package traffic_req_pkg;

   localparam int unsigned DebCntW  = 4;
   localparam int unsigned SvcCntW  = 4;
   localparam int unsigned WaitCntW = 8;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StDebounce = 2'd1,
      StPending  = 2'd2,
      StServing  = 2'd3
   } chan_state_e;

   // Saturates at the all-ones value instead of wrapping.
   function automatic logic [WaitCntW-1:0] wait_inc(input logic [WaitCntW-1:0] cnt);
      if (&cnt) begin
         return cnt;
      end
      return cnt + 1'b1;
   endfunction

endpackage

// File: rtl/traffic_req_chan.sv
// traffic_req_chan
// One street's request channel: 2-flop sensor synchronizer, debounce, sticky
// request held until the street has been green for SERVICE_CYCLES, plus a
// starvation flag.
// Ports:
//   clk_i     : clock, rising edge
//   rst_n_i   : synchronous active-low reset
//   sensor_i  : raw asynchronous vehicle sensor
//   green_i   : controller green for this street
//   waiting_o : registered request to the controller
//   starve_o  : registered, request has waited STARVE_LIMIT cycles
module traffic_req_chan
   import traffic_req_pkg::*;
#(
   parameter int unsigned DEBOUNCE       = 3,
   parameter int unsigned SERVICE_CYCLES = 2,
   parameter int unsigned STARVE_LIMIT   = 15
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic sensor_i,
   input  logic green_i,
   output logic waiting_o,
   output logic starve_o
);

   localparam logic [DebCntW-1:0]  DebTarget    = DebCntW'(DEBOUNCE);
   localparam logic [SvcCntW-1:0]  SvcTarget    = SvcCntW'(SERVICE_CYCLES);
   localparam logic [WaitCntW-1:0] StarveTarget = WaitCntW'(STARVE_LIMIT);

   logic [1:0]          sync_q;
   chan_state_e         state_q, state_d;
   logic [DebCntW-1:0]  deb_q, deb_d, deb_inc;
   logic [SvcCntW-1:0]  svc_q, svc_d, svc_inc;
   logic [WaitCntW-1:0] wait_q, wait_d;
   logic                waiting_q, waiting_d;
   logic                starve_q, starve_d;
   logic                sensor_sync;

   assign sensor_sync = sync_q[1];

   always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      svc_d    = svc_q;
      wait_d   = wait_q;
      starve_d = starve_q;
      deb_inc  = deb_q + 1'b1;
      svc_inc  = svc_q + 1'b1;

      unique case (state_q)
         StIdle: begin
            deb_d    = '0;
            svc_d    = '0;
            wait_d   = '0;
            starve_d = 1'b0;
            if (sensor_sync) begin
               if (DebTarget == 1) begin
                  state_d = StPending;
               end else begin
                  state_d = StDebounce;
                  deb_d   = 1;
               end
            end
         end
         StDebounce: begin
            if (!sensor_sync) begin
               state_d = StIdle;
               deb_d   = '0;
            end else if (deb_inc >= DebTarget) begin
               state_d = StPending;
               deb_d   = '0;
               wait_d  = '0;
            end else begin
               deb_d = deb_inc;
            end
         end
         StPending: begin
            // The sensor is ignored here so a held sensor cannot re-request.
            if (green_i) begin
               state_d  = StServing;
               svc_d    = 1;  // the sampling green cycle counts as service
               wait_d   = '0;
               starve_d = 1'b0;
            end else begin
               wait_d   = wait_inc(wait_q);
               starve_d = (wait_d >= StarveTarget);
            end
         end
         StServing: begin
            starve_d = 1'b0;
            if (svc_q >= SvcTarget || (green_i && svc_inc >= SvcTarget)) begin
               state_d = StIdle;
               deb_d   = '0;
               svc_d   = '0;
               wait_d  = '0;
            end else if (green_i) begin
               svc_d = svc_inc;
            end else begin
               // Green dropped early: the request is still owed.
               state_d = StPending;
               svc_d   = '0;
               wait_d  = '0;
            end
         end
         default: begin
            state_d  = StIdle;
            deb_d    = '0;
            svc_d    = '0;
            wait_d   = '0;
            starve_d = 1'b0;
         end
      endcase

      waiting_d = (state_d == StPending);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sync_q    <= '0;
         state_q   <= StIdle;
         deb_q     <= '0;
         svc_q     <= '0;
         wait_q    <= '0;
         waiting_q <= 1'b0;
         starve_q  <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], sensor_i};
         state_q   <= state_d;
         deb_q     <= deb_d;
         svc_q     <= svc_d;
         wait_q    <= wait_d;
         waiting_q <= waiting_d;
         starve_q  <= starve_d;
      end
   end

   assign waiting_o = waiting_q;
   assign starve_o  = starve_q;

endmodule

// File: rtl/traffic_request_latch.sv
// traffic_request_latch
// Sensor front end for the two-street traffic controller. Two independent
// request channels (main, first) plus a sticky both-green conflict flag.
// Ports:
//   clk           : clock, rising edge
//   rst           : synchronous active-low reset
//   sensor_main   : raw main-street sensor
//   sensor_first  : raw first-street sensor
//   green_main    : controller main-street green
//   green_first   : controller first-street green
//   waiting_main  : registered main-street request
//   waiting_first : registered first-street request
//   starve_main   : main request waited too long
//   starve_first  : first request waited too long
//   conflict_err  : sticky, both greens seen high on one edge
module traffic_request_latch
   import traffic_req_pkg::*;
#(
   parameter int unsigned DEBOUNCE       = 3,
   parameter int unsigned SERVICE_CYCLES = 2,
   parameter int unsigned STARVE_LIMIT   = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic sensor_main,
   input  logic sensor_first,
   input  logic green_main,
   input  logic green_first,
   output logic waiting_main,
   output logic waiting_first,
   output logic starve_main,
   output logic starve_first,
   output logic conflict_err
);

   logic conflict_q, conflict_d;

   traffic_req_chan #(
      .DEBOUNCE       (DEBOUNCE),
      .SERVICE_CYCLES (SERVICE_CYCLES),
      .STARVE_LIMIT   (STARVE_LIMIT)
   ) u_chan_main (
      .clk_i     (clk),
      .rst_n_i   (rst),
      .sensor_i  (sensor_main),
      .green_i   (green_main),
      .waiting_o (waiting_main),
      .starve_o  (starve_main)
   );

   traffic_req_chan #(
      .DEBOUNCE       (DEBOUNCE),
      .SERVICE_CYCLES (SERVICE_CYCLES),
      .STARVE_LIMIT   (STARVE_LIMIT)
   ) u_chan_first (
      .clk_i     (clk),
      .rst_n_i   (rst),
      .sensor_i  (sensor_first),
      .green_i   (green_first),
      .waiting_o (waiting_first),
      .starve_o  (starve_first)
   );

   // Diagnostic only; the channels keep running regardless.
   always_comb begin
      conflict_d = conflict_q | (green_main & green_first);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         conflict_q <= 1'b0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign conflict_err = conflict_q;

endmodule

// File: tb/tb_traffic_request_latch.sv
module tb_traffic_request_latch;

   logic clk;
   logic rst;
   logic sensor_main, sensor_first, green_main, green_first;
   logic waiting_main, waiting_first, starve_main, starve_first, conflict_err;

   int checks_q;
   int failures_q;

   traffic_request_latch #(
      .DEBOUNCE       (3),
      .SERVICE_CYCLES (2),
      .STARVE_LIMIT   (15)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sensor_main   (sensor_main),
      .sensor_first  (sensor_first),
      .green_main    (green_main),
      .green_first   (green_first),
      .waiting_main  (waiting_main),
      .waiting_first (waiting_first),
      .starve_main   (starve_main),
      .starve_first  (starve_first),
      .conflict_err  (conflict_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic obs, input logic exp);
      checks_q++;
      if (obs !== exp) begin
         failures_q++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one rising edge, then settle so outputs can be sampled and
   // inputs changed away from the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wm"}, waiting_main, 1'b0);
      check({tag, "_wf"}, waiting_first, 1'b0);
      check({tag, "_sm"}, starve_main, 1'b0);
      check({tag, "_sf"}, starve_first, 1'b0);
      check({tag, "_ce"}, conflict_err, 1'b0);
   endtask

   initial begin
      checks_q     = 0;
      failures_q   = 0;
      rst          = 1'b0;
      sensor_main  = 1'b0;
      sensor_first = 1'b0;
      green_main   = 1'b0;
      green_first  = 1'b0;

      tick(2);
      check_all_zero("reset");

      rst = 1'b1;
      tick(1);

      // Sensor stable before edge k: waiting after edge k+4 (DEBOUNCE=3).
      sensor_main = 1'b1;
      tick(4);
      check("lat_main_early", waiting_main, 1'b0);
      check("lat_first_idle", waiting_first, 1'b0);
      tick(1);
      check("lat_main_rise", waiting_main, 1'b1);
      check("lat_first_stay", waiting_first, 1'b0);

      // Starvation: wait counter hits 15 on the 15th pending edge.
      tick(14);
      check("starve_pre", starve_main, 1'b0);
      tick(1);
      check("starve_set", starve_main, 1'b1);
      check("starve_wait_held", waiting_main, 1'b1);

      // One green cycle: serve, then green drops early -> back to pending.
      green_main = 1'b1;
      tick(1);
      check("g1_wait_low", waiting_main, 1'b0);
      check("g1_starve_clr", starve_main, 1'b0);
      green_main = 1'b0;
      tick(1);
      check("g1_reassert", waiting_main, 1'b1);
      check("g1_starve_zero", starve_main, 1'b0);

      // Two green cycles retire; held sensor must re-debounce from idle.
      green_main = 1'b1;
      tick(1);
      check("g2_wait_low_a", waiting_main, 1'b0);
      tick(1);
      check("g2_wait_low_b", waiting_main, 1'b0);
      green_main = 1'b0;
      tick(2);
      check("rereq_early", waiting_main, 1'b0);
      tick(1);
      check("rereq_rise", waiting_main, 1'b1);

      // Short first-street pulse: two synchronized highs, never accepted.
      sensor_first = 1'b1;
      tick(2);
      sensor_first = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("pulse_first", waiting_first, 1'b0);
      end
      // Back in idle: a steady request takes the full latency again.
      sensor_first = 1'b1;
      tick(4);
      check("first_lat_early", waiting_first, 1'b0);
      tick(1);
      check("first_lat_rise", waiting_first, 1'b1);

      // Both greens on one edge: sticky conflict.
      green_main  = 1'b1;
      green_first = 1'b1;
      tick(1);
      check("conflict_set", conflict_err, 1'b1);
      green_main  = 1'b0;
      green_first = 1'b0;
      tick(3);
      check("conflict_hold", conflict_err, 1'b1);
      check("conflict_chan_wm", waiting_main, 1'b1);
      check("conflict_chan_wf", waiting_first, 1'b1);

      // Reset mid-request clears everything on the next edge.
      rst = 1'b0;
      tick(1);
      check_all_zero("midreset");

      $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
      $finish;
   end

endmodule
